// File: rtl/uart_rx.sv
`timescale 1ns / 1ps
// uart_rx: UART receive deserializer with 16x oversampling.
//   Samples the synchronised rx line at mid-bit and collects one frame:
//   start, DBIT data bits LSB first, optional parity, then the stop bit.
//   The word is assembled in shift_reg and delivered with the error flags.
//   After a frame whose stop bit read 0 (a break), rx is ignored until the
//   line has been seen high again.
// Optional feature macro: UART_RX_PARITY_EN (adds the parity bit and the check).
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   s_tick       in   1-clk strobe at 16x baud rate
//   rx           in   asynchronous serial input, idle high
//   dout         out  [DBIT-1:0] received word, held until the next frame
//   rx_done_tick out  1-clk pulse when a frame completes
//   frame_err    out  stop bit sampled 0 on the last frame
//   parity_err   out  parity mismatch on the last frame (0 without parity)
module uart_rx #(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err
);

  localparam int unsigned NW     = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [4:0]  S_LAST = 5'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic        ODD_BIT = (PARITY_ODD != 0);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state, state_next;
  logic            rx_meta, rx_s;
  logic [4:0]      s_cnt, s_cnt_next;
  logic [NW-1:0]   n_cnt, n_cnt_next;
  logic [DBIT-1:0] shift_reg, shift_next;
  logic            break_guard, guard_next;
  logic            done_next;
`ifdef UART_RX_PARITY_EN
  logic            par_bit, par_next;
`endif

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      state        <= IDLE;
      s_cnt        <= '0;
      n_cnt        <= '0;
      shift_reg    <= '0;
      break_guard  <= 1'b0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      rx_meta      <= rx;
      rx_s         <= rx_meta;
      state        <= state_next;
      s_cnt        <= s_cnt_next;
      n_cnt        <= n_cnt_next;
      shift_reg    <= shift_next;
      break_guard  <= guard_next;
      rx_done_tick <= done_next;
`ifdef UART_RX_PARITY_EN
      par_bit      <= par_next;
`endif
      // Stop sample is rx_s at the STOP exit edge, so it lands with dout.
      if (done_next) begin
        dout      <= shift_reg;
        frame_err <= ~rx_s;
`ifdef UART_RX_PARITY_EN
        parity_err <= ((^shift_reg) ^ ODD_BIT) != par_bit;
`endif
      end
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0 & ODD_BIT;
`endif

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (!break_guard && !rx_s) state_next = START;
      START: if (s_tick && s_cnt == 5'd7) state_next = rx_s ? IDLE : DATA;
      DATA:
        if (s_tick && s_cnt == 5'd15 && n_cnt == N_LAST) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
      PARITY: if (s_tick && s_cnt == 5'd15) state_next = STOP;
`endif
      STOP:  if (s_tick && s_cnt == S_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counter, shifter and completion logic
  always_comb begin
    s_cnt_next = s_cnt;
    n_cnt_next = n_cnt;
    shift_next = shift_reg;
    guard_next = break_guard;
    done_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_next   = par_bit;
`endif
    case (state)
      IDLE:
        if (break_guard) begin
          if (rx_s) guard_next = 1'b0;
        end else if (!rx_s) begin
          s_cnt_next = '0;
        end
      START:
        if (s_tick) begin
          if (s_cnt == 5'd7) begin
            s_cnt_next = '0;
            n_cnt_next = '0;
          end else begin
            s_cnt_next = s_cnt + 5'd1;
          end
        end
      DATA:
        if (s_tick) begin
          if (s_cnt == 5'd15) begin
            s_cnt_next = '0;
            shift_next = {rx_s, shift_reg[DBIT-1:1]};
            if (n_cnt != N_LAST) n_cnt_next = n_cnt + 1'b1;
          end else begin
            s_cnt_next = s_cnt + 5'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
      PARITY:
        if (s_tick) begin
          if (s_cnt == 5'd15) begin
            s_cnt_next = '0;
            par_next   = rx_s;
          end else begin
            s_cnt_next = s_cnt + 5'd1;
          end
        end
`endif
      STOP:
        if (s_tick) begin
          if (s_cnt == S_LAST) begin
            s_cnt_next = '0;
            done_next  = 1'b1;
            guard_next = ~rx_s;
          end else begin
            s_cnt_next = s_cnt + 5'd1;
          end
        end
      default: ;
    endcase
  end

endmodule
